ifetch_queue: RTL and testbench

Instruction prefetch queue between a handshaked instruction memory and the CPU's IF/ID pipeline register. It runs ahead of the pipeline, fetching sequential words into a DEPTH-entry FIFO. Each word is presented to the IF stage with its PC and PC+4. On a taken branch or jump, the queue flushes and restarts fetch at the redirect target. A response to a request already in flight at that point is drained and discarded.

---
 rtl/ifetch_queue.sv | 231 +++++++++++++++++++++++
 tb/tb_ifetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction prefetch queue. It sits between a handshaked instruction
// memory and the IF/ID pipeline register. The block fetches sequential words
// ahead of the pipeline into a DEPTH-entry FIFO. Each FIFO entry holds a
// {pc, code} pair. A pipeline redirect empties the FIFO and restarts fetch
// at the target address. If a memory response is still in flight when the
// redirect arrives, that response is drained and thrown away.
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset, released synchronously
//   redirect_valid : one-cycle pulse for a taken branch or jump
//   redirect_pc    : word-aligned redirect target
//   mem_req        : memory request, held until it is acknowledged
//   mem_addr       : request address, stable while mem_req is waiting
//   mem_ack        : memory accepts the request, mem_rdata valid this cycle
//   mem_rdata      : returned instruction word
//   out_valid      : head entry is presentable to IF/ID
//   out_ready      : IF/ID takes the head entry (low while ID stalls)
//   out_pc         : PC of the head entry
//   out_pc4        : out_pc + 4
//   out_code       : instruction word of the head entry
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] out_code
);

  localparam int unsigned     PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

  // REQ    : a live request is on the bus, and its data will be queued.
  // DISCARD: a request issued before a redirect is still pending. Its data
  //          belongs to the old path and is dropped.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  fetchState_t      state_r;
  fetchState_t      stateNext_s;
  logic             memReq_r;
  logic             memReqNext_s;
  logic [31:0]      memAddr_r;
  logic [31:0]      memAddrNext_s;
  logic [31:0]      fetchPc_r;
  logic [31:0]      fetchPcNext_s;
  logic [31:0]      pcInc_s;

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] countAfter_s;
  logic [PTR_W-1:0] rdPtr_r;
  logic [PTR_W-1:0] wrPtr_r;
  logic [31:0]      pcMem_r   [DEPTH];
  logic [31:0]      codeMem_r [DEPTH];

  logic             outValid_s;
  logic             push_s;
  logic             pop_s;

  // Queue handshake qualifiers, and the occupancy after this cycle's traffic.
  always_comb begin
    // A redirect hides the head at once, so a stale entry is never consumed.
    outValid_s = (count_r != {CNT_W{1'b0}}) && !redirect_valid;
    pop_s      = outValid_s && out_ready;
    // Only a REQ-state response is pushed. DISCARD responses are dropped.
    push_s     = (state_r == REQ) && memReq_r && mem_ack && !redirect_valid;
    if (push_s && !pop_s) begin
      countAfter_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      countAfter_s = count_r - CNT_ONE;
    end else begin
      countAfter_s = count_r;
    end
  end

  // The sequential address wraps naturally from 32'hFFFF_FFFC to 0.
  assign pcInc_s = fetchPc_r + 32'd4;

  // Fetch FSM next-state and next request/address computation.
  always_comb begin
    stateNext_s   = state_r;
    memReqNext_s  = memReq_r;
    memAddrNext_s = memAddr_r;
    fetchPcNext_s = fetchPc_r;
    case (state_r)
      IDLE: begin
        if (redirect_valid) begin
          stateNext_s   = REQ;
          memReqNext_s  = 1'b1;
          memAddrNext_s = redirect_pc;
          fetchPcNext_s = redirect_pc;
        end else if (countAfter_s < DEPTH_C) begin
          stateNext_s   = REQ;
          memReqNext_s  = 1'b1;
          memAddrNext_s = fetchPc_r;
        end else begin
          stateNext_s   = IDLE;
          memReqNext_s  = 1'b0;
          memAddrNext_s = fetchPc_r;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          if (mem_ack) begin
            // The returned word is from the old path. Restart immediately.
            stateNext_s   = REQ;
            memReqNext_s  = 1'b1;
            memAddrNext_s = redirect_pc;
            fetchPcNext_s = redirect_pc;
          end else begin
            // The bus request must stay stable until it is acknowledged.
            stateNext_s   = DISCARD;
            fetchPcNext_s = redirect_pc;
          end
        end else if (mem_ack) begin
          fetchPcNext_s = pcInc_s;
          memAddrNext_s = pcInc_s;
          if (countAfter_s < DEPTH_C) begin
            stateNext_s  = REQ;
            memReqNext_s = 1'b1;
          end else begin
            stateNext_s  = IDLE;
            memReqNext_s = 1'b0;
          end
        end else begin
          stateNext_s = REQ;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          stateNext_s   = REQ;
          memReqNext_s  = 1'b1;
          if (redirect_valid) begin
            memAddrNext_s = redirect_pc;
            fetchPcNext_s = redirect_pc;
          end else begin
            memAddrNext_s = fetchPc_r;
          end
        end else if (redirect_valid) begin
          fetchPcNext_s = redirect_pc;
        end else begin
          stateNext_s = DISCARD;
        end
      end
      default: begin
        stateNext_s   = IDLE;
        memReqNext_s  = 1'b0;
        memAddrNext_s = fetchPc_r;
      end
    endcase
  end

  // Fetch FSM state, bus request and fetch address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      memReq_r  <= 1'b0;
      memAddr_r <= RESET_PC;
      fetchPc_r <= RESET_PC;
    end else begin
      state_r   <= stateNext_s;
      memReq_r  <= memReqNext_s;
      memAddr_r <= memAddrNext_s;
      fetchPc_r <= fetchPcNext_s;
    end
  end

  // Occupancy and pointers. A redirect has priority over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
    end else if (redirect_valid) begin
      count_r <= {CNT_W{1'b0}};
      rdPtr_r <= {PTR_W{1'b0}};
      wrPtr_r <= {PTR_W{1'b0}};
    end else begin
      count_r <= countAfter_s;
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
    end
  end

  // Entry storage. Entries are cleared on reset so the head outputs reset to
  // known values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pcMem_r[i]   <= 32'h0000_0000;
        codeMem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pcMem_r[wrPtr_r]   <= memAddr_r;
      codeMem_r[wrPtr_r] <= mem_rdata;
    end
  end

  assign mem_req   = memReq_r;
  assign mem_addr  = memAddr_r;
  assign out_valid = outValid_s;
  assign out_pc    = pcMem_r[rdPtr_r];
  assign out_code  = codeMem_r[rdPtr_r];
  assign out_pc4   = pcMem_r[rdPtr_r] + 32'd4;

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//
// Directed bench for ifetch_queue with DEPTH=4 and RESET_PC=0x3000.
// The memory model returns addr ^ 0xA5A5_0000. It runs in one of two modes:
//   - zero-wait: mem_ack follows mem_req in the same cycle.
//   - latency:   mem_ack rises in the third cycle of each request.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready      = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_code;

  logic        latMode        = 1'b0;
  int unsigned held;
  int          checks         = 0;
  int          failures       = 0;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc4(out_pc4),
    .out_code(out_code)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;
  assign mem_ack   = latMode ? (mem_req && (held == 2)) : mem_req;

  // Number of cycles the current request has already waited.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) held <= 0;
    else if (mem_req && mem_ack) held <= 0;
    else if (mem_req) held <= held + 1;
    else held <= 0;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset(input logic lat, input logic rdy);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; latMode = lat; out_ready = rdy;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; latMode = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%h exp=0", mem_req); end
    checks++; if (mem_addr !== 32'h3000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00003000", mem_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_pc4 !== 32'h4) begin failures++; $display("FAIL reset_out_pc4 got=%h exp=4", out_pc4); end
    checks++; if (out_code !== 32'h0) begin failures++; $display("FAIL reset_out_code got=%h exp=0", out_code); end
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL release_mem_req got=%h exp=0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%h exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h3000) begin failures++; $display("FAIL first_addr got=%h exp=00003000", mem_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL first_cycle_valid got=%h exp=0", out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] expPc;
    doReset(1'b0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      expPc = 32'h3000 + 32'(4 * i);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid%0d got=%h exp=1", i, out_valid); end
      checks++; if (out_pc !== expPc) begin failures++; $display("FAIL stream_pc%0d got=%h exp=%h", i, out_pc, expPc); end
      checks++; if (out_pc4 !== expPc + 32'd4) begin failures++; $display("FAIL stream_pc4_%0d got=%h exp=%h", i, out_pc4, expPc + 32'd4); end
      checks++; if (out_code !== (expPc ^ 32'hA5A5_0000)) begin failures++; $display("FAIL stream_code%0d got=%h exp=%h", i, out_code, expPc ^ 32'hA5A5_0000); end
    end
  endtask

  task automatic test_stall();
    int xfers;
    logic [31:0] expPc;
    xfers = 0;
    doReset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_req && mem_ack) xfers++;
    end
    checks++; if (xfers != 4) begin failures++; $display("FAIL stall_xfers got=%0d exp=4", xfers); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stall_req_drop got=%h exp=0", mem_req); end
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      expPc = 32'h3000 + 32'(4 * i);
      checks++; if (out_valid !== 1'b1 || out_pc !== expPc) begin failures++; $display("FAIL stall_drain%0d got=%h/%h exp=1/%h", i, out_valid, out_pc, expPc); end
      if (i == 1) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3010) begin failures++; $display("FAIL stall_resume got=%h/%h exp=1/00003010", mem_req, mem_addr); end
      end
      step();
    end
  endtask

  task automatic test_latency_redirect();
    logic found;
    found = 1'b0;
    doReset(1'b1, 1'b1);
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (mem_req && mem_addr == 32'h3008) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL lat_req3008 got=absent exp=present"); end
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_redir_valid got=%h exp=0", out_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3008) begin failures++; $display("FAIL lat_addr_hold got=%h/%h exp=1/00003008", mem_req, mem_addr); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4000) begin failures++; $display("FAIL lat_target_req got=%h/%h exp=1/00004000", mem_req, mem_addr); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (out_valid) found = 1'b1;
    end
    checks++; if (!found || out_pc !== 32'h4000) begin failures++; $display("FAIL lat_first_out got=%h/%h exp=1/00004000", found, out_pc); end
  endtask

  task automatic test_redirect_ack();
    doReset(1'b0, 1'b0);
    step(); step(); step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin failures++; $display("FAIL rack_pre got=%h/%h exp=1/00003000", out_valid, out_pc); end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h5000;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rack_valid got=%h exp=0", out_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rack_empty got=%h exp=0", out_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h5000) begin failures++; $display("FAIL rack_req got=%h/%h exp=1/00005000", mem_req, mem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h5000) begin failures++; $display("FAIL rack_out got=%h/%h exp=1/00005000", out_valid, out_pc); end
    checks++; if (out_code !== 32'hA5A5_5000) begin failures++; $display("FAIL rack_code got=%h exp=a5a55000", out_code); end
  endtask

  task automatic test_double_redirect();
    logic sawBad;
    logic found;
    sawBad = 1'b0; found = 1'b0;
    doReset(1'b1, 1'b1);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h6000;
    #1;
    step();
    redirect_pc = 32'h7000;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin failures++; $display("FAIL dbl_hold1 got=%h/%h exp=1/00003000", mem_req, mem_addr); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h3000) begin failures++; $display("FAIL dbl_hold2 got=%h exp=00003000", mem_addr); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h7000) begin failures++; $display("FAIL dbl_target got=%h/%h exp=1/00007000", mem_req, mem_addr); end
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_req && mem_addr == 32'h6000) sawBad = 1'b1;
      if (out_valid) found = 1'b1;
    end
    checks++; if (sawBad) begin failures++; $display("FAIL dbl_no6000 got=fetched exp=not_fetched"); end
    checks++; if (!found || out_pc !== 32'h7000) begin failures++; $display("FAIL dbl_first_out got=%h/%h exp=1/00007000", found, out_pc); end
  endtask

  task automatic test_wrap();
    doReset(1'b0, 1'b1);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffff8", mem_addr); end
    step();
    checks++; if (mem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr1 got=%h exp=fffffffc", mem_addr); end
    checks++; if (out_pc !== 32'hFFFF_FFF8 || out_pc4 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_out0 got=%h/%h exp=fffffff8/fffffffc", out_pc, out_pc4); end
    step();
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr2 got=%h exp=00000000", mem_addr); end
    checks++; if (out_pc !== 32'hFFFF_FFFC || out_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_out1 got=%h/%h exp=fffffffc/00000000", out_pc, out_pc4); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_pc4 !== 32'h4) begin failures++; $display("FAIL wrap_out2 got=%h/%h/%h exp=1/00000000/00000004", out_valid, out_pc, out_pc4); end
  endtask

  task automatic test_async_reset();
    doReset(1'b0, 1'b1);
    repeat (4) step();
    checks++; if (mem_req !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%h/%h exp=1/1", mem_req, out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h3000) begin failures++; $display("FAIL arst_mem got=%h/%h exp=0/00003000", mem_req, mem_addr); end
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("FAIL arst_out got=%h/%h exp=0/00000000", out_valid, out_pc); end
    checks++; if (out_pc4 !== 32'h4 || out_code !== 32'h0) begin failures++; $display("FAIL arst_pc4_code got=%h/%h exp=00000004/00000000", out_pc4, out_code); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency_redirect();
    test_redirect_ack();
    test_double_redirect();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
